// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store initiator for the data-memory port.
// Accepts byte/half/word requests on a valid/ready handshake and drives the
// Ewr/Erd/Addr/RDir -> MOut memory interface. Sub-word stores are done as
// read-modify-write. Loaded data is sign- or zero-extended.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests are rejected with rsp_err. When it is undefined, the
// offending low address bits are forced to zero and the access proceeds.
module dmem_access_ctrl #(
  parameter int MEM_WORDS = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Ewr,
  output logic              Erd,
  output logic [DATA_W-1:0] Addr,
  output logic [DATA_W-1:0] RDir,
  input  logic [DATA_W-1:0] MOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [DATA_W-1:0] IDX_MASK = DATA_W'(MEM_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              ewr_q, ewr_d;
  logic              erd_q, erd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdir_q, rdir_d;
  logic              rspValid_q, rspValid_d;
  logic [DATA_W-1:0] rspRdata_q, rspRdata_d;

  logic              reqIsHalf;
  logic              reqIsWord;
  logic [1:0]        reqLane;
  logic [DATA_W-1:0] reqIdx;

  // Pick the addressed byte/half out of a memory word and extend it to full width.
  function automatic logic [DATA_W-1:0] extendLoad(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane,
                                                   input logic sgn);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    byteVal = word[{lane, 3'b000} +: 8];
    halfVal = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extendLoad = {{(DATA_W-8){sgn & byteVal[7]}}, byteVal};
      2'b01:   extendLoad = {{(DATA_W-16){sgn & halfVal[15]}}, halfVal};
      default: extendLoad = word;
    endcase
  endfunction

  // Overwrite the addressed lane(s) of the old memory word with the store data.
  function automatic logic [DATA_W-1:0] mergeStore(input logic [DATA_W-1:0] oldWord,
                                                   input logic [15:0] wdata,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane);
    logic [DATA_W-1:0] merged;
    merged = oldWord;
    if (size == 2'b00) begin
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    end else begin
      merged[{lane[1], 4'b0000} +: 16] = wdata;
    end
    mergeStore = merged;
  endfunction

  // Decode the incoming request: size class, aligned lane and wrapped word index.
  always_comb begin
    reqIsHalf = (req_size == 2'b01);
    reqIsWord = req_size[1];
    reqIdx    = {2'b00, req_addr[DATA_W-1:2]} & IDX_MASK;
    if (reqIsWord) begin
      reqLane = 2'b00;
    end else if (reqIsHalf) begin
      reqLane = {req_addr[1], 1'b0};
    end else begin
      reqLane = req_addr[1:0];
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic rspErr_q, rspErr_d;
  logic reqMisaligned;

  // A half access needs addr[0]=0, a word access needs addr[1:0]=0.
  always_comb begin
    reqMisaligned = (reqIsHalf && req_addr[0]) || (reqIsWord && (req_addr[1:0] != 2'b00));
  end
`endif

  // Next-state and next-output logic for the IDLE/RD/WR/RESP sequencer.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    rdir_d     = rdir_q;
    rspRdata_d = rspRdata_q;
    ewr_d      = 1'b0;
    erd_d      = 1'b0;
    rspValid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    rspErr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = reqLane;
          wdata_d  = req_wdata[15:0];
`ifdef MISALIGN_TRAP_EN
          if (reqMisaligned) begin
            state_d    = RESP;
            rspValid_d = 1'b1;
            rspErr_d   = 1'b1;
            rspRdata_d = '0;
          end else
`endif
          if (req_we && reqIsWord) begin
            state_d = WR;
            ewr_d   = 1'b1;
            addr_d  = reqIdx;
            rdir_d  = req_wdata;
          end else begin
            state_d = RD;
            erd_d   = 1'b1;
            addr_d  = reqIdx;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d = WR;
          ewr_d   = 1'b1;
          rdir_d  = mergeStore(MOut, wdata_q, size_q, lane_q);
        end else begin
          state_d    = RESP;
          rspValid_d = 1'b1;
          rspRdata_d = extendLoad(MOut, size_q, lane_q, signed_q);
        end
      end
      WR: begin
        state_d    = RESP;
        rspValid_d = 1'b1;
        rspRdata_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      ewr_q      <= 1'b0;
      erd_q      <= 1'b0;
      addr_q     <= '0;
      rdir_q     <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      rspErr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      ewr_q      <= ewr_d;
      erd_q      <= erd_d;
      addr_q     <= addr_d;
      rdir_q     <= rdir_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
`ifdef MISALIGN_TRAP_EN
      rspErr_q   <= rspErr_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign Ewr       = ewr_q;
  assign Erd       = erd_q;
  assign Addr      = addr_q;
  assign RDir      = rdir_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
`ifdef MISALIGN_TRAP_EN
  assign rsp_err   = rspErr_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl.
// A behavioural 32-word memory answers the Addr/MOut port. Directed requests
// push their expected responses and expected memory writes into queues, and
// a monitor pops and compares whenever the DUT shows rsp_valid or Ewr.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Ewr;
  logic        Erd;
  logic [31:0] Addr;
  logic [31:0] RDir;
  logic [31:0] MOut;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } rspT;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wrT;

  rspT         rspQ[$];
  wrT          wrQ[$];
  logic [31:0] mem[32];
  int          cycleCount;
  int          testsRun;
  int          testsFailed;

  dmem_access_ctrl #(.MEM_WORDS(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .Ewr        (Ewr),
    .Erd        (Erd),
    .Addr       (Addr),
    .RDir       (RDir),
    .MOut       (MOut)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time responses relative to acceptance.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  // Behavioural data memory: combinational read, write on the rising edge.
  assign MOut = mem[Addr[4:0]];

  always @(posedge clk) begin
    if (Ewr) begin
      mem[Addr[4:0]] <= RDir;
    end
  end

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait for req_ready, issue one request and queue what it should produce.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int delta,
                               input logic expWr, input logic [31:0] expWAddr,
                               input logic [31:0] expWData);
    rspT r;
    wrT  w;
    int  waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL readyTimeout: got req_ready=0, expected 1 within 40 cycles");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    r.rdata = expRdata;
    r.err   = expErr;
    r.cycle = cycleCount + delta;
    rspQ.push_back(r);
    if (expWr) begin
      w.addr = expWAddr;
      w.data = expWData;
      wrQ.push_back(w);
    end
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a response or a write.
  initial begin
    rspT r;
    wrT  w;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rspQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedRsp: got rsp_valid=1 with rdata 0x%08h, expected none", rsp_rdata);
        end else begin
          r = rspQ.pop_front();
          checkOutput("rspRdata", rsp_rdata, r.rdata);
          checkOutput("rspErr", {31'd0, rsp_err}, {31'd0, r.err});
          checkOutput("rspCycle", 32'(cycleCount), 32'(r.cycle));
        end
      end
      if (Ewr) begin
        checkOutput("ewrErdExclusive", {31'd0, Erd}, 32'd0);
        if (wrQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedWrite: got Ewr=1 Addr=0x%08h RDir=0x%08h, expected none", Addr, RDir);
        end else begin
          w = wrQ.pop_front();
          checkOutput("writeAddr", Addr, w.addr);
          checkOutput("writeData", RDir, w.data);
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    cycleCount  = 0;
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", {31'd0, req_ready}, 32'd0);
    checkOutput("resetEwr", {31'd0, Ewr}, 32'd0);
    checkOutput("resetErd", {31'd0, Erd}, 32'd0);
    checkOutput("resetAddr", Addr, 32'd0);
    checkOutput("resetRDir", RDir, 32'd0);
    checkOutput("resetRspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("resetRspRdata", rsp_rdata, 32'd0);
    checkOutput("resetRspErr", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Word store and word load at 0x10 (word 4).
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1, 32'd4, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Clear word 4, then byte store 0xA5 into lane 1 (upper wdata bits must be ignored).
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1, 1'b1, 32'd4, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456A5, 32'h0, 1'b0, 2, 1'b1, 32'd4, 32'h0000A500);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000A500, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Signed and unsigned byte loads from lane 1.
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000A5, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Half loads on 0x80010000.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h80010000, 32'h0, 1'b0, 1, 1'b1, 32'd4, 32'h80010000);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00000000, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Half store into upper lane: 0x80010000 -> 0xBEEF0000.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFEBEEF, 32'h0, 1'b0, 2, 1'b1, 32'd4, 32'hBEEF0000);
    // Misaligned half load at 0x13.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'd0, 32'd0);
`else
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0000BEEF, 1'b0, 1, 1'b0, 32'd0, 32'd0);
`endif
    // Address wrap: 0x84 targets word 1.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h84, 32'h12345678, 32'h0, 1'b0, 1, 1'b1, 32'd1, 32'h12345678);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Byte store into lane 3 of word 1.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h07, 32'h0000007F, 32'h0, 1'b0, 2, 1'b1, 32'd1, 32'h7F345678);
    // Misaligned word load at 0x06.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'd0, 32'd0);
`else
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h7F345678, 1'b0, 1, 1'b0, 32'd0, 32'd0);
`endif
    // Byte store into lane 2 of word 0, then signed byte load through a wrapped address.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h02, 32'h00000080, 32'h0, 1'b0, 2, 1'b1, 32'd0, 32'h00800000);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h82, 32'h0, 32'hFFFFFF80, 1'b0, 1, 1'b0, 32'd0, 32'd0);
    // Size 11 behaves as a word load.
    applyStimulus(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 32'hBEEF0000, 1'b0, 1, 1'b0, 32'd0, 32'd0);

    // Reset during the Erd cycle of a byte store: no write must follow.
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h11;
    req_wdata = 32'h00000055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("abortErd", {31'd0, Erd}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortEwr", {31'd0, Ewr}, 32'd0);
    checkOutput("abortErdCleared", {31'd0, Erd}, 32'd0);
    checkOutput("abortReady", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF0000, 1'b0, 1, 1'b0, 32'd0, 32'd0);

    repeat (6) @(negedge clk);
    checkOutput("rspQueueDrained", 32'(rspQ.size()), 32'd0);
    checkOutput("wrQueueDrained", 32'(wrQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
